// File: rtl/pulse_cnt_pkg.sv
// pulse_cnt_pkg
// Shared constants and helpers for the pulse counting blocks.
//   SAT_WRAP / SAT_SATURATE : values for the SAT overflow-mode parameter
//   ph_width(div)           : width of a phase index for a group of div edges
package pulse_cnt_pkg;

  localparam int SAT_WRAP     = 0;
  localparam int SAT_SATURATE = 1;

  // A phase index always needs at least one bit, even for DIV=1 where it
  // only ever holds 0.
  function automatic int ph_width(input int div);
    int w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// pulse_edge_det
// Rising-edge detector for a level-sampled request. A request held high for
// many cycles produces a single rise; a new rise needs d low for at least one
// sampled cycle.
// Ports:
//   clk  : clock, rising edge active
//   rst  : asynchronous active-high reset (previous sample forced low)
//   d    : level input
//   rise : high while d is 1 and its previous sampled value was 0
module pulse_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  // Previous-cycle sample. Cleared by reset so a request already high when
  // reset releases still registers as an edge on the first active posedge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/pulse_nth_counter.sv
// pulse_nth_counter
// Counts every DIV-th rising edge of inc, the counted edge being the one at
// index PHASE within each group of DIV edges. Overflow either wraps (with a
// one-cycle wrap flag) or saturates at all-ones.
// Parameters:
//   WIDTH : width of cnt (>= 1)
//   DIV   : edges per group (>= 1)
//   PHASE : counted edge index inside a group (0 <= PHASE < DIV)
//   SAT   : SAT_WRAP or SAT_SATURATE
// Ports:
//   clk  : clock, rising edge active
//   rst  : asynchronous active-high reset
//   inc  : event request, only 0->1 transitions count
//   clr  : synchronous clear of count and phase; wins over a coincident edge
//   cnt  : event count
//   ph   : current phase index within the group
//   wrap : one-cycle flag after cnt rolled from all-ones to 0
//   full : cnt is all-ones
module pulse_nth_counter
  import pulse_cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 2,
  parameter int PHASE = 0,
  parameter int SAT   = SAT_WRAP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  input  logic                      clr,
  output logic [WIDTH-1:0]          cnt,
  output logic [ph_width(DIV)-1:0]  ph,
  output logic                      wrap,
  output logic                      full
);

  localparam int PW = ph_width(DIV);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [PW-1:0]    PH_LAST  = PW'(DIV - 1);
  localparam logic [PW-1:0]    PH_MATCH = PW'(PHASE);

  // Parameter sanity, rejected at elaboration.
  if (WIDTH < 1) begin : g_bad_width
    $error("pulse_nth_counter: WIDTH must be >= 1");
  end
  if (DIV < 1) begin : g_bad_div
    $error("pulse_nth_counter: DIV must be >= 1");
  end
  if (PHASE < 0 || PHASE >= DIV) begin : g_bad_phase
    $error("pulse_nth_counter: PHASE must satisfy 0 <= PHASE < DIV");
  end
  if (SAT != SAT_WRAP && SAT != SAT_SATURATE) begin : g_bad_sat
    $error("pulse_nth_counter: SAT must be SAT_WRAP or SAT_SATURATE");
  end

  logic             rise;
  logic [WIDTH-1:0] cnt_nxt;
  logic [PW-1:0]    ph_nxt;
  logic             wrap_nxt;

  pulse_edge_det u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (inc),
    .rise (rise)
  );

  // Next-state for phase, count and wrap flag. The clear discards a
  // coincident edge entirely; the edge detector still samples inc, so a
  // request held through the clear is not recounted afterwards. The phase
  // advances on every edge, including one that saturates or wraps the count.
  always_comb begin
    cnt_nxt  = cnt;
    ph_nxt   = ph;
    wrap_nxt = 1'b0;
    if (clr) begin
      cnt_nxt = '0;
      ph_nxt  = '0;
    end else if (rise) begin
      ph_nxt = (ph == PH_LAST) ? '0 : ph + PW'(1);
      if (ph == PH_MATCH) begin
        if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + WIDTH'(1);
        end else if (SAT == SAT_WRAP) begin
          cnt_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      ph   <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      ph   <= ph_nxt;
      wrap <= wrap_nxt;
    end
  end

  // Derived from the registered count only, so it cannot glitch mid-cycle.
  assign full = (cnt == CNT_MAX);

endmodule

// File: tb/tb_pulse_nth_counter.sv
// tb_pulse_nth_counter
// Four counter instances with different parameter sets share clock and reset
// and each get their own inc/clr bit:
//   u0: DIV=2 PHASE=0 wrap   u1: DIV=1 wrap
//   u2: DIV=3 PHASE=2 wrap   u3: DIV=2 PHASE=0 saturate
// A behavioural model tracks, per instance, the number of edges and the
// number of counted edges since the last clear/reset and derives the
// expected outputs arithmetically from those totals.
module tb_pulse_nth_counter;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] inc_v;
  logic [3:0] clr_v;
  logic [3:0] cnt0, cnt1, cnt2, cnt3;
  logic       ph0, ph1, ph3;
  logic [1:0] ph2;
  logic [3:0] wrap_v;
  logic [3:0] full_v;

  int passed = 0;
  int total  = 0;

  int div_m[N]   = '{2, 1, 3, 2};
  int phase_m[N] = '{0, 0, 2, 0};
  int sat_m[N]   = '{0, 0, 0, 1};

  int edges_m[N];
  int quals_m[N];
  bit prev_m[N];
  bit wrap_m[N];

  int pulse_idx = 0;
  int wrap0_cnt = 0;
  int wrap0_at  = 0;
  int wrap3_cnt = 0;

  pulse_nth_counter #(.WIDTH(4), .DIV(2), .PHASE(0), .SAT(0)) u0 (
    .clk(clk), .rst(rst), .inc(inc_v[0]), .clr(clr_v[0]),
    .cnt(cnt0), .ph(ph0), .wrap(wrap_v[0]), .full(full_v[0]));
  pulse_nth_counter #(.WIDTH(4), .DIV(1), .PHASE(0), .SAT(0)) u1 (
    .clk(clk), .rst(rst), .inc(inc_v[1]), .clr(clr_v[1]),
    .cnt(cnt1), .ph(ph1), .wrap(wrap_v[1]), .full(full_v[1]));
  pulse_nth_counter #(.WIDTH(4), .DIV(3), .PHASE(2), .SAT(0)) u2 (
    .clk(clk), .rst(rst), .inc(inc_v[2]), .clr(clr_v[2]),
    .cnt(cnt2), .ph(ph2), .wrap(wrap_v[2]), .full(full_v[2]));
  pulse_nth_counter #(.WIDTH(4), .DIV(2), .PHASE(0), .SAT(1)) u3 (
    .clk(clk), .rst(rst), .inc(inc_v[3]), .clr(clr_v[3]),
    .cnt(cnt3), .ph(ph3), .wrap(wrap_v[3]), .full(full_v[3]));

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act == exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int expCnt(input int i);
    if (sat_m[i] != 0) return (quals_m[i] > 15) ? 15 : quals_m[i];
    return quals_m[i] % 16;
  endfunction

  function automatic int expPh(input int i);
    return edges_m[i] % div_m[i];
  endfunction

  function automatic int actCnt(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  function automatic int actPh(input int i);
    case (i)
      0: return int'(ph0);
      1: return int'(ph1);
      2: return int'(ph2);
      default: return int'(ph3);
    endcase
  endfunction

  // Reference model: edge and counted-edge totals since the last clear.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        edges_m[i] = 0;
        quals_m[i] = 0;
        prev_m[i]  = 1'b0;
        wrap_m[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        wrap_m[i] = 1'b0;
        if (clr_v[i]) begin
          edges_m[i] = 0;
          quals_m[i] = 0;
        end else if (inc_v[i] && !prev_m[i]) begin
          if (edges_m[i] % div_m[i] == phase_m[i]) begin
            quals_m[i]++;
            if (sat_m[i] == 0 && quals_m[i] % 16 == 0) wrap_m[i] = 1'b1;
          end
          edges_m[i]++;
        end
        prev_m[i] = inc_v[i];
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("cnt%0d", i), actCnt(i), expCnt(i));
      checkOutput($sformatf("ph%0d", i), actPh(i), expPh(i));
      checkOutput($sformatf("wrap%0d", i), int'(wrap_v[i]), int'(wrap_m[i]));
      checkOutput($sformatf("full%0d", i), int'(full_v[i]), (expCnt(i) == 15) ? 1 : 0);
    end
  end

  // Wrap-flag occurrence log for the directed overflow scenario.
  always @(negedge clk) begin
    if (wrap_v[0]) begin
      wrap0_cnt++;
      wrap0_at = pulse_idx;
    end
    if (wrap_v[3]) wrap3_cnt++;
  end

  task automatic applyStimulus(input logic [3:0] inc_n, input logic [3:0] clr_n);
    @(negedge clk);
    #1;
    inc_v = inc_n;
    clr_v = clr_n;
  endtask

  task automatic sendPulses(input logic [3:0] mask, input int n);
    for (int k = 1; k <= n; k++) begin
      pulse_idx = k;
      applyStimulus(mask, 4'b0000);
      repeat (3) applyStimulus(4'b0000, 4'b0000);
    end
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("async_rst_cnt%0d", i), actCnt(i), 0);
      checkOutput($sformatf("async_rst_ph%0d", i), actPh(i), 0);
      checkOutput($sformatf("async_rst_wrap%0d", i), int'(wrap_v[i]), 0);
      checkOutput($sformatf("async_rst_full%0d", i), int'(full_v[i]), 0);
    end
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    inc_v = 4'b0000;
    clr_v = 4'b0000;
    repeat (3) @(negedge clk);
    checkOutput("reset_cnt0", int'(cnt0), 0);
    checkOutput("reset_full3", int'(full_v[3]), 0);
    #1;
    rst = 1'b0;

    // 40 single pulses to the wrapping and the saturating DIV=2 instances.
    sendPulses(4'b1001, 40);
    checkOutput("wrap_cnt0_final", int'(cnt0), 4);
    checkOutput("model_cnt0_final", expCnt(0), 4);
    checkOutput("wrap_ph0_final", int'(ph0), 0);
    checkOutput("wrap0_occurrences", wrap0_cnt, 1);
    checkOutput("wrap0_after_pulse", wrap0_at, 31);
    checkOutput("sat_cnt3_final", int'(cnt3), 15);
    checkOutput("model_cnt3_final", expCnt(3), 15);
    checkOutput("sat_full3", int'(full_v[3]), 1);
    checkOutput("sat_wrap3_occurrences", wrap3_cnt, 0);

    // Held request on the DIV=1 instance counts once.
    repeat (10) applyStimulus(4'b0010, 4'b0000);
    repeat (2) applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0010, 4'b0000);
    repeat (2) applyStimulus(4'b0000, 4'b0000);
    checkOutput("held_cnt1", int'(cnt1), 2);
    checkOutput("model_held_cnt1", expCnt(1), 2);

    // DIV=3, PHASE=2: only every third edge counts.
    sendPulses(4'b0100, 2);
    checkOutput("div3_cnt_after2", int'(cnt2), 0);
    checkOutput("div3_ph_after2", int'(ph2), 2);
    sendPulses(4'b0100, 1);
    checkOutput("div3_cnt_after3", int'(cnt2), 1);
    checkOutput("div3_ph_after3", int'(ph2), 0);
    sendPulses(4'b0100, 6);
    checkOutput("div3_cnt_after9", int'(cnt2), 3);
    checkOutput("model_div3_cnt", expCnt(2), 3);

    // Clear coincident with an edge, request held through the clear.
    applyStimulus(4'b0000, 4'b0001);
    applyStimulus(4'b0000, 4'b0000);
    sendPulses(4'b0001, 9);
    checkOutput("preclr_cnt0", int'(cnt0), 5);
    checkOutput("preclr_ph0", int'(ph0), 1);
    applyStimulus(4'b0001, 4'b0001);
    applyStimulus(4'b0001, 4'b0000);
    checkOutput("clr_cnt0", int'(cnt0), 0);
    checkOutput("clr_ph0", int'(ph0), 0);
    repeat (3) applyStimulus(4'b0001, 4'b0000);
    checkOutput("held_after_clr_cnt0", int'(cnt0), 0);
    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0001, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("reedge_cnt0", int'(cnt0), 1);
    checkOutput("reedge_ph0", int'(ph0), 1);

    // Asynchronous reset mid-cycle with cnt=7, then resume.
    applyStimulus(4'b0000, 4'b0001);
    applyStimulus(4'b0000, 4'b0000);
    sendPulses(4'b0001, 13);
    checkOutput("prerst_cnt0", int'(cnt0), 7);
    pulseReset();
    sendPulses(4'b0001, 2);
    checkOutput("postrst_cnt0", int'(cnt0), 1);
    checkOutput("postrst_ph0", int'(ph0), 0);

    // Random traffic on all instances, with rare clears and resets.
    for (int c = 0; c < 600; c++) begin
      logic [3:0] inc_r;
      logic [3:0] clr_r;
      inc_r = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++) clr_r[b] = ($urandom_range(0, 19) == 0);
      applyStimulus(inc_r, clr_r);
      if (c % 150 == 149) pulseReset();
    end
    applyStimulus(4'b0000, 4'b0000);
    applyStimulus(4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
